alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle controller that sequences the shared W-bit ALU.
- Owns a small register file and accepts one instruction at a time over a valid/ready handshake. An instruction is either an ALU operation on two registers or a load-immediate.
- Drives the external combinational ALU instance, writes the result back, holds the N/Z/CO/OVF flags, and pulses done per retired instruction.

Parameters:
W, 4, datapath width; must match the ALU instance.
NREG, 4, number of registers in the register file.
AW, 2, register index width; NREG = 2**AW.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  instruction present.
in_ready  output  1  sequencer can accept; high only in IDLE.
in_load  input  1  1 = load-immediate, 0 = ALU operation.
in_cntl  input  3  ALU opcode passed to the ALU (000 add … 111 xnor).
in_rd  input  AW  destination register.
in_ra  input  AW  operand A register.
in_rb  input  AW  operand B register.
in_imm  input  W  immediate for load.
alu_a  output  W  ALU operand A.
alu_b  output  W  ALU operand B.
alu_cntl  output  3  ALU opcode.
alu_out  input  W  ALU result.
alu_co, alu_ovf, alu_n, alu_z  input  1 each  ALU flags.
result  output  W  last written value (registered).
flag_n, flag_z, flag_co, flag_ovf  output  1 each  registered flags.
done  output  1  one-cycle pulse on instruction retire.
op_count  output  8  retired-instruction counter, wraps 255 -> 0.
dbg_addr  input  AW  debug read index.
dbg_data  output  W  combinational read of regfile[dbg_addr].

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset (async, active-low): state=IDLE; all registers=0; result=0; all flags=0; done=0; op_count=0.
- FSM states are IDLE, EXEC, RETIRE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1, latch the in_* fields and go to EXEC.
  - Otherwise stay in IDLE.
- EXEC (1 cycle):
  - ALU op: alu_a=reg[ra_q], alu_b=reg[rb_q], alu_cntl=cntl_q. At the edge, reg[rd_q]<=alu_out, result<=alu_out, and all four flags <= ALU flags.
  - Load: at the edge, reg[rd_q]<=imm_q and result<=imm_q; flags unchanged; ALU outputs ignored.
  - Next state is RETIRE.
- RETIRE (1 cycle): done=1; op_count increments (8-bit wrap); next state is IDLE.
- Throughput: accept-to-done latency is 2 cycles (accept edge, EXEC edge, done high during RETIRE). Minimum spacing is 3 cycles per instruction.
- ALU drive outside EXEC (or during a load): alu_a, alu_b and alu_cntl are 0.
- in_ready=0 in EXEC and RETIRE. in_valid is ignored there; in_* may change freely without effect.
- Aliasing: rd may equal ra and/or rb. Operands are read before the write edge, so the old value is used.
- Back-to-back dependency: the write completes before the next accept, so a following instruction reads the new value. No bypass is needed.
- Debug port: dbg_data reflects a write on the cycle after the EXEC edge.
- Flags: CO/OVF semantics are whatever the ALU reports (for subtract, CO = borrow bit of the extended result). Logical ops clear CO/OVF via the ALU.
- Reset mid-operation: the instruction is abandoned. No write occurs, no done pulse, and op_count is not incremented.

Test Plan:
- Load R1=7, R2=1, then ADD (000) R3=R1+R2. Required: result=8, reg3=8, flag_n=1, flag_ovf=1, flag_co=0, flag_z=0. done pulses exactly 2 cycles after each accept; op_count=3.
- R1=3, R2=5, SUB A-B (001) R0=R1-R2. Required: result=0xE, flag_co=1, flag_n=1, flag_ovf=0. Then SUB R0=R2-R2: result=0, flag_z=1.
- Aliasing: R1=6, then XOR (110) R1=R1^R1. Required: alu_a=alu_b=6 during EXEC, reg1=0, flag_z=1. Then a load leaves flags unchanged (flag_z remains 1).
- Back-pressure: hold in_valid=1 with changing fields for 6 cycles. Required: exactly 2 instructions accepted (at cycles 0 and 3), in_ready low in EXEC and RETIRE, and fields sampled only at the accept edges.
- Reset mid-EXEC: assert rst_n=0 asynchronously during EXEC of a load R2=9. Required: regs, result, flags and op_count all 0 immediately; done never pulses; in_ready=1 after release.
- Counter wrap: retire 256 loads. Required: op_count returns to 0; dbg_addr sweep matches the expected register contents.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer for a shared external ALU: accepts one instruction at a time,
// drives the ALU, writes back to a small register file and holds the result flags.
//
// state  | meaning
// IDLE   | in_ready high; an instruction is latched on in_valid
// EXEC   | ALU driven (or immediate selected); write-back at the closing edge
// RETIRE | done high; op_count advances at the closing edge
module alu_sequencer #(
    parameter int W    = 4,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_load,
    input  logic [2:0]    in_cntl,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_ra,
    input  logic [AW-1:0] in_rb,
    input  logic [W-1:0]  in_imm,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [2:0]    alu_cntl,
    input  logic [W-1:0]  alu_out,
    input  logic          alu_co,
    input  logic          alu_ovf,
    input  logic          alu_n,
    input  logic          alu_z,
    output logic [W-1:0]  result,
    output logic          flag_n,
    output logic          flag_z,
    output logic          flag_co,
    output logic          flag_ovf,
    output logic          done,
    output logic [7:0]    op_count,
    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_RETIRE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            load_q, load_d;
    logic [2:0]      cntl_q, cntl_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [AW-1:0]   ra_q, ra_d;
    logic [AW-1:0]   rb_q, rb_d;
    logic [W-1:0]    imm_q, imm_d;
    logic [W-1:0]    regs_q [NREG];
    logic [W-1:0]    regs_d [NREG];
    logic [W-1:0]    result_q, result_d;
    logic [3:0]      flags_q, flags_d;   // {n, z, co, ovf}
    logic [7:0]      count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            load_q   <= 1'b0;
            cntl_q   <= '0;
            rd_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            imm_q    <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            result_q <= '0;
            flags_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            load_q   <= load_d;
            cntl_q   <= cntl_d;
            rd_q     <= rd_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            imm_q    <= imm_d;
            regs_q   <= regs_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_d   = load_q;
        cntl_d   = cntl_q;
        rd_d     = rd_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        imm_d    = imm_q;
        regs_d   = regs_q;
        result_d = result_q;
        flags_d  = flags_q;
        count_d  = count_q;
        in_ready = 1'b0;
        done     = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_cntl = '0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_d  = in_load;
                    cntl_d  = in_cntl;
                    rd_d    = in_rd;
                    ra_d    = in_ra;
                    rb_d    = in_rb;
                    imm_d   = in_imm;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Operands come from regs_q, so rd aliasing ra/rb sees the pre-write value.
                if (load_q) begin
                    regs_d[rd_q] = imm_q;
                    result_d     = imm_q;
                end else begin
                    alu_a        = regs_q[ra_q];
                    alu_b        = regs_q[rb_q];
                    alu_cntl     = cntl_q;
                    regs_d[rd_q] = alu_out;
                    result_d     = alu_out;
                    flags_d      = {alu_n, alu_z, alu_co, alu_ovf};
                end
                state_d = S_RETIRE;
            end
            S_RETIRE: begin
                done    = 1'b1;
                count_d = count_q + 8'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign result   = result_q;
    assign flag_n   = flags_q[3];
    assign flag_z   = flags_q[2];
    assign flag_co  = flags_q[1];
    assign flag_ovf = flags_q[0];
    assign op_count = count_q;
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed and random instructions checked against a
// register-file/flags model, with a behavioural ALU standing in for the shared instance.
module tb_alu_sequencer;

    localparam int W    = 4;
    localparam int AW   = 2;
    localparam int NREG = 4;

    typedef struct packed {
        logic          ld;
        logic [2:0]    op;
        logic [AW-1:0] rd;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [W-1:0]  imm;
    } instr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_load;
    logic [2:0]    in_cntl;
    logic [AW-1:0] in_rd, in_ra, in_rb;
    logic [W-1:0]  in_imm;
    logic [W-1:0]  alu_a, alu_b, alu_out;
    logic [2:0]    alu_cntl;
    logic          alu_co, alu_ovf, alu_n, alu_z;
    logic [W-1:0]  result;
    logic          flag_n, flag_z, flag_co, flag_ovf, done;
    logic [7:0]    op_count;
    logic [AW-1:0] dbg_addr;
    logic [W-1:0]  dbg_data;

    int n_tests;
    int n_fail;

    logic [W-1:0] m_regs [NREG];
    logic [W-1:0] m_result;
    logic [3:0]   m_flags;   // {n, z, co, ovf}
    int           m_count;

    always #5 clk = ~clk;

    alu_sequencer #(.W(W), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_cntl(in_cntl),
        .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cntl(alu_cntl), .alu_out(alu_out),
        .alu_co(alu_co), .alu_ovf(alu_ovf), .alu_n(alu_n), .alu_z(alu_z),
        .result(result), .flag_n(flag_n), .flag_z(flag_z), .flag_co(flag_co),
        .flag_ovf(flag_ovf), .done(done), .op_count(op_count),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Returns {co, ovf, n, z, out} using integer arithmetic on unsigned/signed views.
    function automatic logic [W+3:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
        int ua = int'(a);
        int ub = int'(b);
        int sa = a[W-1] ? ua - (1 << W) : ua;
        int sb = b[W-1] ? ub - (1 << W) : ub;
        int full = 0;
        int sfull = 0;
        logic [W-1:0] r = '0;
        logic co = 1'b0;
        logic ovf = 1'b0;
        case (op)
            3'd0: begin
                full = ua + ub;
                sfull = sa + sb;
                r = full[W-1:0];
                co = (full >= (1 << W));
                ovf = (sfull > (1 << (W-1)) - 1) || (sfull < -(1 << (W-1)));
            end
            3'd1: begin
                full = ua - ub;
                sfull = sa - sb;
                r = full[W-1:0];
                co = (full < 0);
                ovf = (sfull > (1 << (W-1)) - 1) || (sfull < -(1 << (W-1)));
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = ~(a & b);
            3'd5: r = ~(a | b);
            3'd6: r = a ^ b;
            default: r = ~(a ^ b);
        endcase
        return {co, ovf, r[W-1], (r == '0), r};
    endfunction

    always_comb {alu_co, alu_ovf, alu_n, alu_z, alu_out} = alu_fn(alu_a, alu_b, alu_cntl);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        m_result = '0;
        m_flags  = '0;
        m_count  = 0;
    endfunction

    // Applies one instruction to the model; returns the ALU drive expected during EXEC.
    function automatic void m_apply(input instr_t ins, output logic [W-1:0] ea,
                                    output logic [W-1:0] eb, output logic [2:0] ec);
        logic [W+3:0] r;
        if (ins.ld) begin
            ea = '0;
            eb = '0;
            ec = '0;
            m_regs[ins.rd] = ins.imm;
            m_result = ins.imm;
        end else begin
            ea = m_regs[ins.ra];
            eb = m_regs[ins.rb];
            ec = ins.op;
            r = alu_fn(m_regs[ins.ra], m_regs[ins.rb], ins.op);
            m_regs[ins.rd] = r[W-1:0];
            m_result = r[W-1:0];
            m_flags = {r[W+1], r[W], r[W+3], r[W+2]};
        end
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.ld  = ($urandom_range(0, 3) == 0);
        i.op  = 3'($urandom);
        i.rd  = AW'($urandom);
        i.ra  = AW'($urandom);
        i.rb  = AW'($urandom);
        i.imm = W'($urandom);
        return i;
    endfunction

    task automatic drive(input instr_t i);
        in_load = i.ld;
        in_cntl = i.op;
        in_rd   = i.rd;
        in_ra   = i.ra;
        in_rb   = i.rb;
        in_imm  = i.imm;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_result"}, 32'(result), 32'(m_result));
        chk({tag, "_flags"}, 32'({flag_n, flag_z, flag_co, flag_ovf}), 32'(m_flags));
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < NREG; i++) begin
            dbg_addr = AW'(i);
            #1;
            chk(tag, 32'(dbg_data), 32'(m_regs[i]));
        end
    endtask

    task automatic issue(input instr_t ins);
        logic [W-1:0] ea, eb;
        logic [2:0]   ec;
        int budget = 0;
        while (in_ready !== 1'b1 && budget < 10) begin
            tick();
            budget++;
        end
        chk("ready_before_accept", 32'(in_ready), 32'd1);
        drive(ins);
        in_valid = 1'b1;
        tick();
        // EXEC: junk on the inputs must be ignored
        in_valid = 1'($urandom);
        drive(rand_instr());
        m_apply(ins, ea, eb, ec);
        chk("exec_ready", 32'(in_ready), 32'd0);
        chk("exec_done", 32'(done), 32'd0);
        chk("exec_alu_a", 32'(alu_a), 32'(ea));
        chk("exec_alu_b", 32'(alu_b), 32'(eb));
        chk("exec_alu_cntl", 32'(alu_cntl), 32'(ec));
        tick();
        drive(rand_instr());
        chk("retire_done", 32'(done), 32'd1);
        chk("retire_ready", 32'(in_ready), 32'd0);
        check_state("retire");
        dbg_addr = ins.rd;
        #1;
        chk("retire_dbg", 32'(dbg_data), 32'(m_regs[ins.rd]));
        m_count = (m_count + 1) % 256;
        tick();
        in_valid = 1'b0;
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("op_count", 32'(op_count), 32'(m_count));
    endtask

    function automatic instr_t mk(input logic ld, input logic [2:0] op, input int rd,
                                  input int ra, input int rb, input int imm);
        instr_t i;
        i.ld  = ld;
        i.op  = op;
        i.rd  = AW'(rd);
        i.ra  = AW'(ra);
        i.rb  = AW'(rb);
        i.imm = W'(imm);
        return i;
    endfunction

    initial begin
        instr_t bp [6];
        logic [W-1:0] ea, eb;
        logic [2:0]   ec;

        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        drive(mk(1'b0, 3'd0, 0, 0, 0, 0));
        dbg_addr = '0;
        m_reset();
        #12;
        rst_n = 1'b1;
        tick();

        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        check_state("rst");
        sweep("rst_dbg");

        // Load / add with signed overflow
        issue(mk(1'b1, 3'd0, 1, 0, 0, 7));
        issue(mk(1'b1, 3'd0, 2, 0, 0, 1));
        issue(mk(1'b0, 3'd0, 3, 1, 2, 0));
        chk("add_result", 32'(result), 32'h8);
        chk("add_nzco", 32'({flag_n, flag_z, flag_co, flag_ovf}), 32'b1001);
        chk("add_count", 32'(op_count), 32'd3);
        dbg_addr = 2'd3;
        #1;
        chk("add_reg3", 32'(dbg_data), 32'h8);

        // Subtract with borrow, then subtract to zero
        issue(mk(1'b1, 3'd0, 1, 0, 0, 3));
        issue(mk(1'b1, 3'd0, 2, 0, 0, 5));
        issue(mk(1'b0, 3'd1, 0, 1, 2, 0));
        chk("sub_result", 32'(result), 32'hE);
        chk("sub_nzco", 32'({flag_n, flag_z, flag_co, flag_ovf}), 32'b1010);
        issue(mk(1'b0, 3'd1, 0, 2, 2, 0));
        chk("sub0_result", 32'(result), 32'h0);
        chk("sub0_z", 32'(flag_z), 32'd1);

        // Full aliasing, then a load that must not touch flags
        issue(mk(1'b1, 3'd0, 1, 0, 0, 6));
        issue(mk(1'b0, 3'd6, 1, 1, 1, 0));
        chk("xor_z", 32'(flag_z), 32'd1);
        dbg_addr = 2'd1;
        #1;
        chk("xor_reg1", 32'(dbg_data), 32'h0);
        issue(mk(1'b1, 3'd0, 2, 0, 0, 4'hA));
        chk("load_keeps_z", 32'(flag_z), 32'd1);
        chk("load_result", 32'(result), 32'hA);

        // in_valid held high for six cycles: accepts only at cycles 0 and 3
        for (int k = 0; k < 6; k++) begin
            bp[k] = rand_instr();
            drive(bp[k]);
            in_valid = 1'b1;
            chk("bp_ready", 32'(in_ready), 32'((k % 3) == 0));
            chk("bp_done", 32'(done), 32'((k % 3) == 2));
            if ((k % 3) == 1) begin
                m_apply(bp[k-1], ea, eb, ec);
                chk("bp_alu_a", 32'(alu_a), 32'(ea));
                chk("bp_alu_b", 32'(alu_b), 32'(eb));
                chk("bp_alu_cntl", 32'(alu_cntl), 32'(ec));
            end
            if ((k % 3) == 2) m_count = (m_count + 1) % 256;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_count", 32'(op_count), 32'(m_count));
        check_state("bp");
        sweep("bp_dbg");

        // Asynchronous reset during EXEC of a load
        tick();
        drive(mk(1'b1, 3'd0, 2, 0, 0, 9));
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_count", 32'(op_count), 32'd0);
        check_state("mid_rst");
        sweep("mid_rst_dbg");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_ready", 32'(in_ready), 32'd1);
            chk("post_rst_count", 32'(op_count), 32'd0);
        end
        sweep("post_rst_dbg");

        // 256 loads wrap the retire counter back to zero
        for (int k = 0; k < 256; k++) begin
            instr_t i;
            i = rand_instr();
            i.ld = 1'b1;
            issue(i);
        end
        chk("wrap_count", 32'(op_count), 32'd0);
        sweep("wrap_dbg");

        // Random mix of operations
        for (int k = 0; k < 80; k++) issue(rand_instr());
        sweep("rand_dbg");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
